// File: rtl/ccip_if_pkg.sv
// rtl/ccip_if_pkg.sv - CCI-P interface widths shared across the AFU wrapper
package ccip_if_pkg;
    localparam int CCIP_C1TX_HDR_WIDTH = 80;
    localparam int CCIP_CLDATA_WIDTH   = 512;
endpackage

// File: rtl/ccip_throttle_pkg.sv
// rtl/ccip_throttle_pkg.sv - shared constants for the CCI-P throttle blocks
package ccip_throttle_pkg;
    localparam int CCIP_THROTTLE_STAT_WIDTH = 32;
endpackage

// File: rtl/ccip_sync_fifo.sv
// rtl/ccip_sync_fifo.sv - single-clock FIFO, first-word-fall-through read, registered count
module ccip_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_wr) - CW'(do_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end
endmodule

// File: rtl/ccip_c1tx_throttle.sv
// rtl/ccip_c1tx_throttle.sv - c1Tx elastic buffer gated by platform almost-full; CCIP_C1TX_THROTTLE_STATS_EN adds counters
module ccip_c1tx_throttle
    import ccip_if_pkg::*;
    import ccip_throttle_pkg::*;
#(
    parameter int DEPTH         = 64,
    parameter int ALMFULL_SLACK = 8
) (
    input  logic                           pClk,
    input  logic                           pck_cp2af_softReset_n,
    input  logic [CCIP_C1TX_HDR_WIDTH-1:0] in_c1Tx_hdr,
    input  logic [CCIP_CLDATA_WIDTH-1:0]   in_c1Tx_data,
    input  logic                           in_c1Tx_valid,
    output logic                           in_c1TxAlmFull,
    input  logic                           c1TxAlmFull,
    output logic [CCIP_C1TX_HDR_WIDTH-1:0] c1Tx_hdr,
    output logic [CCIP_CLDATA_WIDTH-1:0]   c1Tx_data,
    output logic                           c1Tx_valid,
    output logic [$clog2(DEPTH+1)-1:0]     occupancy,
    output logic                           overflow_err
`ifdef CCIP_C1TX_THROTTLE_STATS_EN
    ,
    output logic [CCIP_THROTTLE_STAT_WIDTH-1:0] stat_issued,
    output logic [CCIP_THROTTLE_STAT_WIDTH-1:0] stat_stall_cycles,
    output logic [CCIP_THROTTLE_STAT_WIDTH-1:0] stat_peak_occ
`endif
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int FW = CCIP_C1TX_HDR_WIDTH + CCIP_CLDATA_WIDTH;
    localparam logic [CW-1:0] ALM_THRESH = CW'(DEPTH - ALMFULL_SLACK);

    logic [FW-1:0] head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push_ok;
    logic          pop;
    logic [CW-1:0] next_occ;

    // Full is judged on start-of-cycle state, so a same-cycle pop never rescues a push.
    assign push_ok  = in_c1Tx_valid && !fifo_full;
    assign pop      = !fifo_empty && !c1TxAlmFull;
    assign next_occ = occupancy + CW'(push_ok) - CW'(pop);

    ccip_sync_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (pClk),
        .rst_n   (pck_cp2af_softReset_n),
        .wr_en   (in_c1Tx_valid),
        .wr_data ({in_c1Tx_hdr, in_c1Tx_data}),
        .rd_en   (pop),
        .rd_data (head),
        .count   (occupancy),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
        if (!pck_cp2af_softReset_n) begin
            c1Tx_valid     <= 1'b0;
            c1Tx_hdr       <= '0;
            c1Tx_data      <= '0;
            in_c1TxAlmFull <= 1'b0;
            overflow_err   <= 1'b0;
        end else begin
            c1Tx_valid     <= pop;
            in_c1TxAlmFull <= (next_occ >= ALM_THRESH);
            if (in_c1Tx_valid && fifo_full) overflow_err <= 1'b1;
            if (pop) {c1Tx_hdr, c1Tx_data} <= head;
        end
    end

`ifdef CCIP_C1TX_THROTTLE_STATS_EN
    always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
        if (!pck_cp2af_softReset_n) begin
            stat_issued       <= '0;
            stat_stall_cycles <= '0;
            stat_peak_occ     <= '0;
        end else begin
            if (c1Tx_valid) stat_issued <= stat_issued + 1'b1;
            if (!fifo_empty && c1TxAlmFull && (stat_stall_cycles != '1))
                stat_stall_cycles <= stat_stall_cycles + 1'b1;
            if (CCIP_THROTTLE_STAT_WIDTH'(occupancy) > stat_peak_occ)
                stat_peak_occ <= CCIP_THROTTLE_STAT_WIDTH'(occupancy);
        end
    end
`endif
endmodule

// File: tb/tb_ccip_c1tx_throttle.sv
// tb/tb_ccip_c1tx_throttle.sv - self-checking bench for ccip_c1tx_throttle
module tb_ccip_c1tx_throttle;
    import ccip_if_pkg::*;

    localparam int DEPTH = 64;
    localparam int SLACK = 8;
    localparam int HW    = CCIP_C1TX_HDR_WIDTH;
    localparam int DW    = CCIP_CLDATA_WIDTH;
    localparam int CW    = $clog2(DEPTH+1);

    logic          pClk;
    logic          rst_n;
    logic [HW-1:0] in_hdr;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_alm;
    logic          plat_alm;
    logic [HW-1:0] c1Tx_hdr;
    logic [DW-1:0] c1Tx_data;
    logic          c1Tx_valid;
    logic [CW-1:0] occupancy;
    logic          overflow_err;
`ifdef CCIP_C1TX_THROTTLE_STATS_EN
    logic [31:0]   stat_issued;
    logic [31:0]   stat_stall_cycles;
    logic [31:0]   stat_peak_occ;
`endif

    ccip_c1tx_throttle #(.DEPTH(DEPTH), .ALMFULL_SLACK(SLACK)) dut (
        .pClk                  (pClk),
        .pck_cp2af_softReset_n (rst_n),
        .in_c1Tx_hdr           (in_hdr),
        .in_c1Tx_data          (in_data),
        .in_c1Tx_valid         (in_valid),
        .in_c1TxAlmFull        (in_alm),
        .c1TxAlmFull           (plat_alm),
        .c1Tx_hdr              (c1Tx_hdr),
        .c1Tx_data             (c1Tx_data),
        .c1Tx_valid            (c1Tx_valid),
        .occupancy             (occupancy),
        .overflow_err          (overflow_err)
`ifdef CCIP_C1TX_THROTTLE_STATS_EN
        ,
        .stat_issued           (stat_issued),
        .stat_stall_cycles     (stat_stall_cycles),
        .stat_peak_occ         (stat_peak_occ)
`endif
    );

    initial begin
        pClk = 1'b0;
        forever #5 pClk = ~pClk;
    end

    logic [HW+DW-1:0] sb[$];
    int tests = 0;
    int fails = 0;
    int n_out = 0;
    int cyc = 0;
    int first_cyc = -1;
    int last_cyc = 0;
    int peak = 0;
    logic prev_alm = 1'b0;

    // Output monitor: every issued request must match the oldest expected one.
    always @(negedge pClk) begin
        logic [HW+DW-1:0] exp_e;
        cyc++;
        if (int'(occupancy) > peak) peak = int'(occupancy);
        if (rst_n && c1Tx_valid) begin
            tests++;
            assert (!prev_alm) else begin
                fails++;
                $error("FAIL valid_after_almfull: got valid=1 expected 0 at cycle %0d", cyc);
            end
            tests++;
            assert (sb.size() != 0) else begin
                fails++;
                $error("FAIL unexpected_out: got hdr %h with empty scoreboard, expected none", c1Tx_hdr);
            end
            if (sb.size() != 0) begin
                exp_e = sb.pop_front();
                tests++;
                assert ({c1Tx_hdr, c1Tx_data} === exp_e) else begin
                    fails++;
                    $error("FAIL out_order: got hdr %h data %h expected hdr %h data %h",
                           c1Tx_hdr, c1Tx_data[31:0], exp_e[HW+DW-1:DW], exp_e[31:0]);
                end
            end
            n_out++;
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
        end
        prev_alm = plat_alm;
    end

    function automatic logic [HW-1:0] mk_hdr(input int i);
        return {16'hC1C1, 32'(i), 32'(i * 7 + 3)};
    endfunction

    function automatic logic [DW-1:0] mk_data(input int i);
        return {16{32'(i) ^ 32'h5A5A_0000}};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic drive_push(input logic [HW-1:0] h, input logic [DW-1:0] d, input bit accept);
        in_hdr   = h;
        in_data  = d;
        in_valid = 1'b1;
        if (accept) sb.push_back({h, d});
        @(posedge pClk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int bound);
        int n = 0;
        while ((sb.size() != 0 || occupancy != 0 || c1Tx_valid) && n < bound) begin
            @(posedge pClk); #1;
            n++;
        end
        check("drain_timeout", 64'(n < bound), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        rst_n = 1'b0; in_hdr = '0; in_data = '0; in_valid = 1'b0; plat_alm = 1'b0;
        repeat (3) @(posedge pClk);
        #1;
        check("rst_valid", 64'(c1Tx_valid), 0);
        check("rst_hdr", 64'(|c1Tx_hdr), 0);
        check("rst_data", 64'(|c1Tx_data), 0);
        check("rst_almfull", 64'(in_alm), 0);
        check("rst_occ", 64'(occupancy), 0);
        check("rst_ovf", 64'(overflow_err), 0);
        rst_n = 1'b1;
        @(posedge pClk); #1;

        // single request: 2-cycle latency, exactly one valid cycle
        n0 = n_out;
        drive_push(HW'(32'hA), DW'(1), 1'b1);
        check("single_occ1", 64'(occupancy), 1);
        check("single_valid_early", 64'(c1Tx_valid), 0);
        @(posedge pClk); #1;
        check("single_valid", 64'(c1Tx_valid), 1);
        check("single_hdr", 64'(c1Tx_hdr), 64'hA);
        check("single_occ0", 64'(occupancy), 0);
        @(posedge pClk); #1;
        check("single_valid_drop", 64'(c1Tx_valid), 0);
        check("single_count", 64'(n_out - n0), 1);

        // back-to-back 20
        n0 = n_out; peak = 0; first_cyc = -1;
        for (int i = 0; i < 20; i++) drive_push(mk_hdr(i), mk_data(i), 1'b1);
        wait_drain(50);
        check("b2b_count", 64'(n_out - n0), 20);
        check("b2b_contiguous", 64'(last_cyc - first_cyc), 19);
        check("b2b_peak_le2", 64'(peak <= 2), 1);

        // platform stall, almost-full threshold at 56
        plat_alm = 1'b1;
        n0 = n_out;
        for (int i = 0; i < 56; i++) begin
            drive_push(mk_hdr(100 + i), mk_data(100 + i), 1'b1);
            check("stall_almfull", 64'(in_alm), 64'((i + 1) >= (DEPTH - SLACK)));
        end
        check("stall_occ", 64'(occupancy), 56);
        check("stall_no_valid", 64'(n_out - n0), 0);
        plat_alm = 1'b0;
        wait_drain(200);
        check("stall_drained", 64'(n_out - n0), 56);
        check("stall_alm_clear", 64'(in_alm), 0);

        // overflow: 65th push dropped, sticky error
        plat_alm = 1'b1;
        check("ovf_before", 64'(overflow_err), 0);
        n0 = n_out;
        for (int i = 0; i < 65; i++) drive_push(mk_hdr(200 + i), mk_data(200 + i), i < DEPTH);
        check("ovf_occ", 64'(occupancy), 64);
        check("ovf_err", 64'(overflow_err), 1);
        plat_alm = 1'b0;
        wait_drain(200);
        check("ovf_drained", 64'(n_out - n0), 64);
        check("ovf_sticky", 64'(overflow_err), 1);

        // platform almost-full toggled mid-burst
        n0 = n_out;
        for (int i = 0; i < 30; i++) begin
            if (i == 10) plat_alm = 1'b1;
            if (i == 15) plat_alm = 1'b0;
            drive_push(mk_hdr(300 + i), mk_data(300 + i), 1'b1);
        end
        wait_drain(100);
        check("burst_count", 64'(n_out - n0), 30);

        // reset mid-operation discards buffered requests
        plat_alm = 1'b1;
        for (int i = 0; i < 10; i++) drive_push(mk_hdr(400 + i), mk_data(400 + i), 1'b1);
        check("rst_mid_occ", 64'(occupancy), 10);
        plat_alm = 1'b0;
        @(posedge pClk); #3;
        check("rst_mid_valid_before", 64'(c1Tx_valid), 1);
        rst_n = 1'b0;
        #1;
        sb.delete();
        check("rst_mid_valid", 64'(c1Tx_valid), 0);
        check("rst_mid_occ0", 64'(occupancy), 0);
        check("rst_mid_ovf", 64'(overflow_err), 0);
        repeat (2) @(posedge pClk);
        #1;
        rst_n = 1'b1;
        n0 = n_out;
        repeat (20) @(posedge pClk);
        #1;
        check("rst_no_stale", 64'(n_out - n0), 0);
        check("rst_post_occ", 64'(occupancy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
